// File: rtl/uart_arbitrator_n.sv
// uart_arbitrator_n
//   Bus-mapped UART: TX FIFO feeding a serial transmitter, a serial receiver
//   feeding an RX FIFO, sticky error flags and a level interrupt.
//
// Ports
//   clock        single clock, rising edge
//   reset        synchronous active-high reset
//   address      register select: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CONTROL
//   writedata    bus write data
//   readdata     registered bus read data (1-cycle latency, held between reads)
//   read, write  bus strobes, qualified by chip_select (write wins over read)
//   chip_select  bus access enable
//   rx           asynchronous serial input, idle high
//   tx           serial output, idle high
//   state        TX FSM state (IDLE 000, START 001, DATA 010, STOP 011)
//   irq          registered level interrupt
module uart_arbitrator_n #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        read,
    input  logic        write,
    input  logic        chip_select,
    input  logic        rx,
    output logic        tx,
    output logic [2:0]  state,
    output logic        irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CLK_ONE  = CW'(1);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE  = 3'b000,
        TX_START = 3'b001,
        TX_DATA  = 3'b010,
        TX_STOP  = 3'b011
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // ---------------- bus decode ----------------
    logic w_wr, w_rd, w_tx_wr, w_rx_rd, w_st_wr, w_ctl_wr;
    assign w_wr     = chip_select & write;
    assign w_rd     = chip_select & read & ~write;
    assign w_tx_wr  = w_wr && (address == 2'd0);
    assign w_st_wr  = w_wr && (address == 2'd2);
    assign w_ctl_wr = w_wr && (address == 2'd3);
    assign w_rx_rd  = w_rd && (address == 2'd1);

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] r_txf [FIFO_DEPTH];
    logic [AW-1:0]        r_txf_wp, r_txf_rp;
    logic [AW:0]          r_txf_cnt;
    logic                 w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
    logic [DATA_BITS-1:0] w_tx_head;

    assign w_tx_empty = (r_txf_cnt == '0);
    assign w_tx_full  = (r_txf_cnt == CNT_FULL);
    assign w_tx_head  = r_txf[r_txf_rp];
    // A full FIFO still accepts a write in the cycle the transmitter pops.
    assign w_tx_push  = w_tx_wr & (~w_tx_full | w_tx_pop);

    always_ff @(posedge clock) begin
        if (w_tx_push) r_txf[r_txf_wp] <= writedata[DATA_BITS-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_txf_wp  <= '0;
            r_txf_rp  <= '0;
            r_txf_cnt <= '0;
        end else begin
            if (w_tx_push) r_txf_wp <= r_txf_wp + PTR_ONE;
            if (w_tx_pop)  r_txf_rp <= r_txf_rp + PTR_ONE;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_txf_cnt <= r_txf_cnt + CNT_ONE;
                2'b01:   r_txf_cnt <= r_txf_cnt - CNT_ONE;
                default: r_txf_cnt <= r_txf_cnt;
            endcase
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t            r_tx_state, w_tx_state_nx;
    logic [CW-1:0]        r_tx_cnt, w_tx_cnt_nx;
    logic [BW-1:0]        r_tx_bit, w_tx_bit_nx;
    logic [DATA_BITS-1:0] r_tx_sh, w_tx_sh_nx;
    logic                 r_tx, w_tx_nx;

    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt + CLK_ONE;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_sh_nx    = r_tx_sh;
        w_tx_pop      = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nx = '0;
                if (!w_tx_empty) begin
                    w_tx_pop      = 1'b1;
                    w_tx_sh_nx    = w_tx_head;
                    w_tx_state_nx = TX_START;
                end
            end
            TX_START: begin
                if (r_tx_cnt == CLK_LAST) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_bit_nx   = '0;
                    w_tx_state_nx = TX_DATA;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == CLK_LAST) begin
                    w_tx_cnt_nx = '0;
                    w_tx_sh_nx  = r_tx_sh >> 1;
                    if (r_tx_bit == BIT_LAST) w_tx_state_nx = TX_STOP;
                    else                      w_tx_bit_nx   = r_tx_bit + BIT_ONE;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == CLK_LAST) begin
                    w_tx_cnt_nx = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!w_tx_empty) begin
                        w_tx_pop      = 1'b1;
                        w_tx_sh_nx    = w_tx_head;
                        w_tx_state_nx = TX_START;
                    end else begin
                        w_tx_state_nx = TX_IDLE;
                    end
                end
            end
            default: begin
                w_tx_cnt_nx   = '0;
                w_tx_state_nx = TX_IDLE;
            end
        endcase
        // tx is registered alongside the state so the pin never glitches.
        case (w_tx_state_nx)
            TX_START: w_tx_nx = 1'b0;
            TX_DATA:  w_tx_nx = w_tx_sh_nx[0];
            default:  w_tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_sh    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_sh    <= w_tx_sh_nx;
            r_tx       <= w_tx_nx;
        end
    end

    // ---------------- RX front end ----------------
    logic [2:0] r_ctrl;
    logic       r_rx_meta, r_rx_sync, r_rx_prev, w_rx_in;

    assign w_rx_in = r_ctrl[2] ? r_tx : r_rx_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= w_rx_in;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t            r_rx_state, w_rx_state_nx;
    logic [CW-1:0]        r_rx_cnt, w_rx_cnt_nx;
    logic [BW-1:0]        r_rx_bit, w_rx_bit_nx;
    logic [DATA_BITS-1:0] r_rx_sh, w_rx_sh_nx;
    logic                 w_rx_push, w_ferr_set;

    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt + CLK_ONE;
        w_rx_bit_nx   = r_rx_bit;
        w_rx_sh_nx    = r_rx_sh;
        w_rx_push     = 1'b0;
        w_ferr_set    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nx = '0;
                if (r_rx_prev && !w_rx_in) w_rx_state_nx = RX_START;
            end
            RX_START: begin
                // Half a bit in: line back high means a glitch, not a start bit.
                if (r_rx_cnt == CLK_HALF) begin
                    w_rx_cnt_nx = '0;
                    w_rx_bit_nx = '0;
                    w_rx_state_nx = w_rx_in ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == CLK_LAST) begin
                    w_rx_cnt_nx = '0;
                    w_rx_sh_nx  = {w_rx_in, r_rx_sh[DATA_BITS-1:1]};
                    if (r_rx_bit == BIT_LAST) w_rx_state_nx = RX_STOP;
                    else                      w_rx_bit_nx   = r_rx_bit + BIT_ONE;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == CLK_LAST) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_state_nx = RX_IDLE;
                    w_rx_push     = w_rx_in;
                    w_ferr_set    = ~w_rx_in;
                end
            end
            default: begin
                w_rx_cnt_nx   = '0;
                w_rx_state_nx = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
        end else begin
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_bit   <= w_rx_bit_nx;
            r_rx_sh    <= w_rx_sh_nx;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] r_rxf [FIFO_DEPTH];
    logic [AW-1:0]        r_rxf_wp, r_rxf_rp;
    logic [AW:0]          r_rxf_cnt;
    logic                 w_rx_empty, w_rx_full, w_rx_pop, w_rx_put, w_ovr_set;

    assign w_rx_empty = (r_rxf_cnt == '0);
    assign w_rx_full  = (r_rxf_cnt == CNT_FULL);
    assign w_rx_pop   = w_rx_rd & ~w_rx_empty;
    // A bus pop in the same cycle makes room for the incoming character.
    assign w_rx_put   = w_rx_push & (~w_rx_full | w_rx_pop);
    assign w_ovr_set  = w_rx_push & w_rx_full & ~w_rx_pop;

    always_ff @(posedge clock) begin
        if (w_rx_put) r_rxf[r_rxf_wp] <= w_rx_sh_nx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rxf_wp  <= '0;
            r_rxf_rp  <= '0;
            r_rxf_cnt <= '0;
        end else begin
            if (w_rx_put) r_rxf_wp <= r_rxf_wp + PTR_ONE;
            if (w_rx_pop) r_rxf_rp <= r_rxf_rp + PTR_ONE;
            case ({w_rx_put, w_rx_pop})
                2'b10:   r_rxf_cnt <= r_rxf_cnt + CNT_ONE;
                2'b01:   r_rxf_cnt <= r_rxf_cnt - CNT_ONE;
                default: r_rxf_cnt <= r_rxf_cnt;
            endcase
        end
    end

    // ---------------- registers, read path, interrupt ----------------
    logic        r_overrun, r_ferr, r_irq;
    logic [31:0] r_readdata, w_status, w_rd_data;

    assign w_status = {25'b0, (r_tx_state != TX_IDLE), r_ferr, r_overrun,
                       w_rx_full, ~w_rx_empty, w_tx_empty, w_tx_full};

    always_comb begin
        w_rd_data = '0;
        case (address)
            2'd1:    if (!w_rx_empty) w_rd_data = 32'(r_rxf[r_rxf_rp]);
            2'd2:    w_rd_data = w_status;
            2'd3:    w_rd_data = {29'b0, r_ctrl};
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_readdata <= '0;
            r_ctrl     <= '0;
            r_overrun  <= 1'b0;
            r_ferr     <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_rd)     r_readdata <= w_rd_data;
            if (w_ctl_wr) r_ctrl     <= writedata[2:0];
            // A new error event wins over a same-cycle clear.
            if (w_ovr_set)                    r_overrun <= 1'b1;
            else if (w_st_wr && writedata[4]) r_overrun <= 1'b0;
            if (w_ferr_set)                   r_ferr    <= 1'b1;
            else if (w_st_wr && writedata[5]) r_ferr    <= 1'b0;
            r_irq <= (r_ctrl[0] & ~w_rx_empty)
                   | (r_ctrl[1] & w_tx_empty & (r_tx_state == TX_IDLE));
        end
    end

    assign readdata = r_readdata;
    assign tx       = r_tx;
    assign state    = r_tx_state;
    assign irq      = r_irq;

endmodule

// File: tb/tb_uart_arbitrator_n.sv
module tb_uart_arbitrator_n;

    localparam int CPB   = 4;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clock = 1'b0;
    logic        reset, read, write, chip_select, rx;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        tx, irq;
    logic [2:0]  state;

    always #5 clock = ~clock;

    uart_arbitrator_n #(
        .DATA_BITS(DB),
        .FIFO_DEPTH(DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .address(address),
        .writedata(writedata),
        .readdata(readdata),
        .read(read),
        .write(write),
        .chip_select(chip_select),
        .rx(rx),
        .tx(tx),
        .state(state),
        .irq(irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Transmitter is a queue plus a position within a 10-bit frame;
    // receiver is a queue of characters delivered once a frame has finished.
    logic [7:0]  m_txq[$];
    logic [7:0]  m_rxq[$];
    bit          m_live = 0;
    bit          m_busy;
    int          m_pos;
    logic [7:0]  m_cur;
    bit          m_ovr, m_ferr;
    logic [2:0]  m_ctrl;
    logic [31:0] m_rd;
    logic        m_irq;
    bit          m_irq_valid;
    logic        m_tx;
    logic [2:0]  m_state;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = (m_txq.size() == DEPTH);
        s[1] = (m_txq.size() == 0);
        s[2] = (m_rxq.size() != 0);
        s[3] = (m_rxq.size() == DEPTH);
        s[4] = m_ovr;
        s[5] = m_ferr;
        s[6] = m_busy;
        return s;
    endfunction

    task automatic rx_deliver(input logic [7:0] c);
        if (m_rxq.size() < DEPTH) m_rxq.push_back(c);
        else m_ovr = 1;
    endtask

    task automatic model_step();
        logic irq_n;
        bit   irqv_n, w, r;
        int   idx;
        if (reset) begin
            m_txq.delete(); m_rxq.delete();
            m_busy = 0; m_pos = 0; m_cur = '0;
            m_ovr = 0; m_ferr = 0; m_ctrl = '0; m_rd = '0;
            m_irq = 0; m_irq_valid = 1; m_tx = 1; m_state = 3'd0;
            m_live = 1;
            return;
        end
        if (!m_live) return;
        irq_n  = (m_ctrl[0] && m_rxq.size() != 0) ||
                 (m_ctrl[1] && m_txq.size() == 0 && !m_busy);
        irqv_n = !m_ctrl[0];
        w = chip_select && write;
        r = chip_select && read && !write;
        if (r) begin
            case (address)
                2'd1:    m_rd = (m_rxq.size() != 0) ? {24'b0, m_rxq.pop_front()} : 32'd0;
                2'd2:    m_rd = m_status();
                2'd3:    m_rd = {29'b0, m_ctrl};
                default: m_rd = 32'd0;
            endcase
        end
        if (!m_busy) begin
            if (m_txq.size() != 0) begin
                m_cur = m_txq.pop_front(); m_busy = 1; m_pos = 0;
            end
        end else if (m_pos == FRAME - 1) begin
            if (m_ctrl[2]) rx_deliver(m_cur);
            if (m_txq.size() != 0) begin
                m_cur = m_txq.pop_front(); m_pos = 0;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_pos++;
        end
        if (w) begin
            case (address)
                2'd0: if (m_txq.size() < DEPTH) m_txq.push_back(writedata[7:0]);
                2'd2: begin
                    if (writedata[4]) m_ovr  = 0;
                    if (writedata[5]) m_ferr = 0;
                end
                2'd3: m_ctrl = writedata[2:0];
                default: ;
            endcase
        end
        m_irq = irq_n;
        m_irq_valid = irqv_n;
        if (!m_busy) begin
            m_tx = 1; m_state = 3'd0;
        end else begin
            idx = m_pos / CPB;
            if (idx == 0)      begin m_tx = 1'b0;          m_state = 3'd1; end
            else if (idx == 9) begin m_tx = 1'b1;          m_state = 3'd3; end
            else               begin m_tx = m_cur[idx-1];  m_state = 3'd2; end
        end
    endtask

    always @(posedge clock) begin
        model_step();
        #1;
        if (m_live) begin
            check("tx", {31'b0, tx}, {31'b0, m_tx});
            check("state", {29'b0, state}, {29'b0, m_state});
            check("readdata", readdata, m_rd);
            if (m_irq_valid) check("irq", {31'b0, irq}, {31'b0, m_irq});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_cycle(input logic cs, input logic rd, input logic wr,
                             input logic [1:0] a, input logic [31:0] d);
        @(negedge clock);
        chip_select = cs; read = rd; write = wr; address = a; writedata = d;
        @(posedge clock);
        #1;
        chip_select = 0; read = 0; write = 0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        bus_cycle(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        bus_cycle(1'b1, 1'b1, 1'b0, a, 32'd0);
        d = readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_rx(input logic [7:0] c, input logic stopb);
        logic [9:0] f;
        f = {stopb, c, 1'b0};
        for (int b = 0; b < 10; b++) begin
            @(negedge clock);
            rx = f[b];
            repeat (CPB - 1) @(negedge clock);
        end
        @(negedge clock);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        if (stopb) rx_deliver(c);
        else m_ferr = 1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    logic [31:0] d;
    logic [9:0]  a5_bits;
    logic [7:0]  ch;
    int          p, k;
    bit          found;

    initial begin
        reset = 1; read = 0; write = 0; chip_select = 0; rx = 1;
        address = '0; writedata = '0;
        idle(3);
        @(posedge clock); #1;
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_state", {29'b0, state}, 32'd0);
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'b0, irq}, 32'd0);
        @(negedge clock); reset = 0;

        // single character 0xA5, bit pattern pinned by hand
        a5_bits = 10'b11_0100_1010;  // index 0 = start bit
        bus_wr(2'd0, 32'h0000_00A5);
        check("a5_state_push_edge", {29'b0, state}, 32'd0);
        @(posedge clock); #1;
        check("a5_state_start", {29'b0, state}, 32'd1);
        p = 0;
        for (int b = 0; b < 10; b++) begin
            while (p < b * CPB + 2) begin @(posedge clock); #1; p++; end
            check($sformatf("a5_bit%0d", b), {31'b0, tx}, {31'b0, a5_bits[b]});
        end
        while (p < FRAME) begin @(posedge clock); #1; p++; end
        check("a5_state_done", {29'b0, state}, 32'd0);
        bus_rd(2'd2, d);
        check("a5_status", d, 32'h02);

        // loopback: two characters come back in order
        bus_wr(2'd3, 32'h4);
        bus_wr(2'd0, 32'h3C);
        bus_wr(2'd0, 32'hC3);
        idle(100);
        bus_rd(2'd2, d);
        check("lb_rx_avail", d & 32'h4, 32'h4);
        bus_wr(2'd3, 32'h5);
        repeat (2) begin @(posedge clock); #1; end
        check("lb_rx_irq", {31'b0, irq}, 32'd1);
        bus_wr(2'd3, 32'h4);
        bus_rd(2'd1, d); check("lb_rd0", d, 32'h3C);
        bus_rd(2'd1, d); check("lb_rd1", d, 32'hC3);
        bus_rd(2'd1, d); check("lb_rd_empty", d, 32'h0);
        bus_rd(2'd2, d); check("lb_rx_avail_clear", d & 32'h4, 32'h0);
        bus_wr(2'd3, 32'h0);

        // overrun: five characters, no reads
        for (int i = 0; i < 5; i++) send_rx(8'($urandom), 1'b1);
        bus_rd(2'd2, d);
        check("ovr_status", d & 32'h1C, 32'h1C);
        bus_wr(2'd2, 32'h10);
        bus_rd(2'd2, d);
        check("ovr_cleared", d & 32'h1C, 32'h0C);
        for (int i = 0; i < DEPTH; i++) bus_rd(2'd1, d);

        // framing error, then a one-cycle glitch
        send_rx(8'h55, 1'b0);
        bus_rd(2'd2, d);
        check("ferr_status", d & 32'h24, 32'h20);
        bus_wr(2'd2, 32'h20);
        @(negedge clock); rx = 0;
        @(negedge clock); rx = 1;
        idle(60);
        bus_rd(2'd2, d);
        check("glitch_status", d & 32'h24, 32'h0);

        // six back-to-back writes: the sixth finds the FIFO full and is dropped
        for (int i = 0; i < 6; i++) bus_wr(2'd0, 32'h10 + i);
        bus_rd(2'd2, d);
        check("burst_full_busy", d & 32'h43, 32'h41);
        idle(7 * FRAME);
        bus_rd(2'd2, d);
        check("burst_drained", d, 32'h02);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2, 3: begin
                    bus_wr(2'd0, $urandom);
                    idle($urandom_range(0, 30));
                end
                4: begin
                    d = $urandom; d[0] = 1'b0; d[2] = 1'b0;
                    bus_wr(2'd3, d);
                end
                5: bus_rd(2'($urandom_range(0, 3)), d);
                6: begin
                    d = $urandom;
                    address = 2'($urandom_range(0, 3));
                    if (address == 2'd3) begin d[0] = 1'b0; d[2] = 1'b0; end
                    bus_cycle(1'($urandom), 1'($urandom), 1'($urandom), address, d);
                end
                7: send_rx(8'($urandom), ($urandom_range(0, 7) != 0));
                default: bus_rd(2'd1, d);
            endcase
        end
        idle(FRAME * (DEPTH + 2));
        for (int i = 0; i <= DEPTH; i++) bus_rd(2'd1, d);
        bus_wr(2'd2, 32'h30);

        // reset in the middle of a data bit
        bus_wr(2'd3, 32'h2);
        bus_wr(2'd0, 32'h5A);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clock); #1;
            if (state == 3'd2) found = 1;
        end
        check("rst_reached_data", {31'b0, found}, 32'd1);
        idle(5);
        reset = 1;
        @(posedge clock); #1;
        check("rst_mid_tx", {31'b0, tx}, 32'd1);
        check("rst_mid_state", {29'b0, state}, 32'd0);
        check("rst_mid_irq", {31'b0, irq}, 32'd0);
        @(negedge clock); reset = 0;
        bus_rd(2'd2, d);
        check("rst_mid_status", d, 32'h02);
        bus_rd(2'd3, d);
        check("rst_mid_control", d, 32'h0);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
